uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmit serializer. Consumes the one-clock-wide bit-rate tick from the baud generator and turns parallel bytes into an asynchronous serial frame on `tx`.
- Frame order: start bit, then 5-8 data bits LSB first, then an optional parity bit, then 1 or 2 stop bits.
- Sits between the UART register/FIFO front end (valid/ready byte handshake) and the serial pin.
- Frame format is set by LCR-style static inputs.

Parameters:
- DATA_W, 8, width of the `tx_data` input. Fixed at 8; `word_len` selects how many bits are sent.
- IDLE_LVL, 1'b1, line level of `tx` in idle, during stop bits and after reset.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  block enable. Deasserting it aborts any frame in progress.
- baud_tick  input  1  one-clk pulse per bit period, from the baud generator (its baud_clk output)
- tx_data  input  8  byte to send
- tx_valid  input  1  `tx_data` is valid
- tx_ready  output  1  block can accept a byte; combinational, = en && (state==IDLE)
- word_len  input  2  00=5, 01=6, 10=7, 11=8 data bits
- stop2  input  1  0 = 1 stop bit, 1 = 2 stop bits
- parity_en  input  1  insert parity bit (used only with UART_TX_PARITY_EN)
- parity_even  input  1  1 = even parity, 0 = odd parity
- tx  output  1  serial line, registered
- tx_busy  output  1  frame pending or in progress, registered

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; tx=1; tx_busy=0; bit counter=0; shift register=0.
  - tx_ready follows en once rst_n=1.
- States: IDLE, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - Handshake completes when tx_valid && tx_ready on a rising clk edge.
  - On that edge: latch tx_data, word_len, stop2, parity_en, parity_even; go to WAIT; tx_busy<=1.
- WAIT:
  - Holds tx=1 until the first baud_tick, so the start bit is aligned to a tick boundary.
  - On that tick: tx<=0; go to START.
- START: on baud_tick, tx<=shreg[0], shift right, count=1, go to DATA.
- DATA:
  - On each baud_tick, if count < N (N = word_len+5): tx<=shreg[0], shift, count++.
  - On the tick where count==N:
    - if parity is active: tx<=parity bit, go to PARITY;
    - else: tx<=1, go to STOP.
- PARITY: on baud_tick, tx<=1, go to STOP, stop counter=1.
- STOP:
  - On baud_tick: if stop2 and stop counter==1, increment it and stay in STOP.
  - Otherwise go to IDLE; tx_busy<=0.
  - tx_ready is 1 in the following cycle.
- Timing:
  - Each bit lasts exactly one baud_tick interval.
  - tx changes only on clk edges where baud_tick=1 (abort excepted).
  - Total frame = 1 + N + P + S tick intervals, measured from the falling edge of the start bit.
- Parity bit:
  - Computed over the N transmitted bits only; bits above N-1 are ignored.
  - Even: XOR of the data bits. Odd: inverted XOR.
- Config/data stability: config and data are latched at handshake. Changes during a frame do not affect it.
- baud_tick in the same cycle as the handshake: ignored. WAIT consumes the next tick.
- Back-to-back frames:
  - A new byte may be accepted in the cycle after STOP→IDLE.
  - That frame enters WAIT, so the line carries at least one full stop bit period between frames.
- en=0 in any non-IDLE state: on the next clk edge, tx<=1, state=IDLE, tx_busy<=0. The frame is dropped with no partial restart.
- en=0 in IDLE: tx_ready=0 and nothing is accepted.
- rst_n asserted mid-frame: outputs return to reset values immediately (asynchronously).
- baud_tick wider than one clk: every high cycle counts as a tick. The generator guarantees single-cycle pulses.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state and parity logic are built. A parity bit is sent when the latched parity_en=1.
- Undefined: no PARITY state or parity logic. parity_en and parity_even are ignored, and frames never contain a parity bit (DATA→STOP directly).

Test Plan:
- 8N1 byte: en=1, word_len=11, stop2=0, parity_en=0, tx_data=0x55, baud_tick every 16 clk.
  -> tx sampled at bit centres = 0,1,0,1,0,1,0,1,0,1.
  -> 10 tick intervals from start-bit fall to idle; tx_busy high throughout; tx_ready returns to 1.
- 8E2 with parity (macro defined): tx_data=0xA3, parity_en=1, parity_even=1, stop2=1.
  -> bits 0,1,1,0,0,0,1,0,1, then parity 0, then stop bits 1,1: 12 tick intervals.
  -> Repeat with parity_even=0: parity bit = 1.
- 5-bit word: word_len=00, tx_data=0xFF.
  -> start 0, five 1s, stop 1; 7 tick intervals.
  -> Parity (odd, if enabled) over the 5 bits = 0.
- Back-to-back: tx_valid held high with 0x0F then 0xF0.
  -> Second handshake occurs in the cycle after the first frame returns to IDLE.
  -> Second start bit begins on the next tick, never mid-stop-bit.
  -> tx_data change during the first frame does not corrupt it.
- Abort and reset:
  - en dropped during DATA bit 3 -> next clk: tx=1, tx_busy=0, state IDLE; no further transitions on later ticks.
  - rst_n pulsed low mid-frame -> tx=1 and tx_busy=0 immediately; after release, the next byte is sent correctly.
- Tick coinciding with handshake: baud_tick=1 in the same cycle as tx_valid&&tx_ready.
  -> tx stays 1 for that tick.
  -> Start bit begins on the following tick.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Define UART_TX_PARITY_EN to build the parity state and parity generator.
module uart_tx #(
    parameter int   DATA_W   = 8,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [1:0]        word_len,
    input  logic              stop2,
    input  logic              parity_en,
    input  logic              parity_even,
    output logic              tx,
    output logic              tx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic              tx_d, busy_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        stop_cnt_q, stop_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [1:0]        wlen_q, wlen_d;
    logic              stop2_q, stop2_d;
    logic [3:0]        n_bits;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_even_q, par_even_d;
    logic par_acc_q, par_acc_d;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = parity_en ^ parity_even;
`endif

    assign n_bits   = {2'b00, wlen_q} + 4'd5;
    assign tx_ready = en && (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx         <= IDLE_LVL;
            tx_busy    <= 1'b0;
            cnt_q      <= 4'd0;
            stop_cnt_q <= 2'd0;
            shreg_q    <= '0;
            wlen_q     <= 2'd0;
            stop2_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_even_q <= 1'b0;
            par_acc_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx         <= tx_d;
            tx_busy    <= busy_d;
            cnt_q      <= cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            wlen_q     <= wlen_d;
            stop2_q    <= stop2_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_even_q <= par_even_d;
            par_acc_q  <= par_acc_d;
`endif
        end
    end

    // Parity accumulates over bits as they leave the shifter, so bits above N-1 never contribute.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx;
        busy_d     = tx_busy;
        cnt_d      = cnt_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        wlen_d     = wlen_q;
        stop2_d    = stop2_q;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_even_d = par_even_q;
        par_acc_d  = par_acc_q;
`endif
        if (state_q != IDLE && !en) begin
            state_d = IDLE;
            tx_d    = IDLE_LVL;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_d = IDLE_LVL;
                    if (tx_valid && en) begin
                        shreg_d    = tx_data;
                        wlen_d     = word_len;
                        stop2_d    = stop2;
`ifdef UART_TX_PARITY_EN
                        par_en_d   = parity_en;
                        par_even_d = parity_even;
`endif
                        busy_d     = 1'b1;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (baud_tick) begin
                        tx_d    = ~IDLE_LVL;
                        state_d = START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        cnt_d     = 4'd1;
`ifdef UART_TX_PARITY_EN
                        par_acc_d = shreg_q[0];
`endif
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (cnt_q < n_bits) begin
                            tx_d      = shreg_q[0];
                            shreg_d   = shreg_q >> 1;
                            cnt_d     = cnt_q + 4'd1;
`ifdef UART_TX_PARITY_EN
                            par_acc_d = par_acc_q ^ shreg_q[0];
`endif
                        end
`ifdef UART_TX_PARITY_EN
                        else if (par_en_q) begin
                            tx_d    = par_acc_q ^ ~par_even_q;
                            state_d = PARITY;
                        end
`endif
                        else begin
                            tx_d       = IDLE_LVL;
                            stop_cnt_d = 2'd1;
                            state_d    = STOP;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        tx_d       = IDLE_LVL;
                        stop_cnt_d = 2'd1;
                        state_d    = STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_tick) begin
                        if (stop2_q && stop_cnt_q == 2'd1) begin
                            stop_cnt_d = stop_cnt_q + 2'd1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    tx_d    = IDLE_LVL;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of expected line bits sampled at bit centres.
// Honours UART_TX_PARITY_EN the same way as the design when building expected frames.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] word_len;
    logic       stop2;
    logic       parity_en;
    logic       parity_even;
    logic       tx;
    logic       tx_busy;

    int n_checks = 0;
    int n_fails  = 0;
    int phase    = 0;

    bit exp_q[$];
    int len_q[$];

    uart_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .baud_tick   (baud_tick),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .word_len    (word_len),
        .stop2       (stop2),
        .parity_en   (parity_en),
        .parity_even (parity_even),
        .tx          (tx),
        .tx_busy     (tx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick: one clock wide every 16 clocks, changed on the falling edge.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            phase     = (phase == 15) ? 0 : phase + 1;
            baud_tick = (phase == 15);
        end
    end

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_frame(input logic [7:0] d, input logic [1:0] wl,
                                       input logic s2, input logic pe, input logic pev);
        int  n;
        int  total;
        logic p;
        logic has_par;
        n     = int'(wl) + 5;
        p     = 1'b0;
        total = 0;
        exp_q.push_back(1'b0);
        total++;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
            total++;
        end
`ifdef UART_TX_PARITY_EN
        has_par = pe;
`else
        has_par = pe & 1'b0;
`endif
        if (has_par) begin
            exp_q.push_back(pev ? p : ~p);
            total++;
        end
        exp_q.push_back(1'b1);
        total++;
        if (s2) begin
            exp_q.push_back(1'b1);
            total++;
        end
        len_q.push_back(total);
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] wl, input logic s2,
                                 input logic pe, input logic pev, input bit push,
                                 input bit align_tick, input bit hold);
        int g;
        tx_data     = d;
        word_len    = wl;
        stop2       = s2;
        parity_en   = pe;
        parity_even = pev;
        if (push) push_frame(d, wl, s2, pe, pev);
        if (align_tick) begin
            g = 0;
            while (baud_tick !== 1'b1 && g < 64) begin
                wait_neg();
                g++;
            end
            check_eq("align_tick", baud_tick, 1'b1);
        end
        tx_valid = 1'b1;
        g = 0;
        while (tx_ready !== 1'b1 && g < 100) begin
            wait_neg();
            g++;
        end
        check_eq("handshake_ready", tx_ready, 1'b1);
        wait_neg();
        tx_valid = hold;
        check_eq("busy_after_accept", tx_busy, 1'b1);
        check_eq("idle_line_in_wait", tx, 1'b1);
    endtask

    task automatic checkOutput(input int exp_wait);
        int len;
        int k;
        bit fell;
        bit e;
        len  = len_q.pop_front();
        k    = 0;
        fell = 0;
        while (!fell && k < 80) begin
            wait_neg();
            k++;
            if (tx === 1'b0) fell = 1;
        end
        check_eq("start_fall", fell, 1'b1);
        if (!fell) begin
            for (int b = 0; b < len; b++) void'(exp_q.pop_front());
            return;
        end
        if (exp_wait >= 0) check_eq("start_delay", k, exp_wait);
        repeat (7) wait_neg();
        for (int b = 0; b < len; b++) begin
            e = exp_q.pop_front();
            check_eq($sformatf("bit%0d", b), tx, e);
            check_eq($sformatf("busy_bit%0d", b), tx_busy, 1'b1);
            if (b < len - 1) repeat (16) wait_neg();
        end
        repeat (8) wait_neg();
        check_eq("busy_last_cycle", tx_busy, 1'b1);
        wait_neg();
        check_eq("busy_end", tx_busy, 1'b0);
        check_eq("ready_end", tx_ready, 1'b1);
    endtask

    initial begin
        int  g;
        int  changes;
        bit  fell;

        rst_n       = 1'b0;
        en          = 1'b1;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        word_len    = 2'b11;
        stop2       = 1'b0;
        parity_en   = 1'b0;
        parity_even = 1'b0;

        repeat (3) wait_neg();
        check_eq("reset_tx", tx, 1'b1);
        check_eq("reset_busy", tx_busy, 1'b0);
        rst_n = 1'b1;
        wait_neg();
        check_eq("ready_after_reset", tx_ready, 1'b1);

        $display("[TB] 8N1 0x55");
        applyStimulus(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1, 0, 0);
        checkOutput(-1);

        $display("[TB] 8E2 / 8O2 0xA3");
        applyStimulus(8'hA3, 2'b11, 1'b1, 1'b1, 1'b1, 1, 0, 0);
        checkOutput(-1);
        applyStimulus(8'hA3, 2'b11, 1'b1, 1'b1, 1'b0, 1, 0, 0);
        checkOutput(-1);

        $display("[TB] short words");
        applyStimulus(8'hFF, 2'b00, 1'b0, 1'b1, 1'b0, 1, 0, 0);
        checkOutput(-1);
        applyStimulus(8'h2A, 2'b01, 1'b0, 1'b1, 1'b1, 1, 0, 0);
        checkOutput(-1);
        applyStimulus(8'h5D, 2'b10, 1'b1, 1'b0, 1'b0, 1, 0, 0);
        checkOutput(-1);

        $display("[TB] back-to-back with config change mid-frame");
        applyStimulus(8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, 1, 0, 1);
        tx_data  = 8'hF0;
        word_len = 2'b10;
        stop2    = 1'b1;
        push_frame(8'hF0, 2'b10, 1'b1, 1'b0, 1'b0);
        checkOutput(-1);
        wait_neg();
        check_eq("b2b_second_accept", tx_busy, 1'b1);
        check_eq("b2b_ready_low", tx_ready, 1'b0);
        tx_valid = 1'b0;
        checkOutput(15);

        $display("[TB] tick coinciding with handshake");
        applyStimulus(8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 1, 1, 0);
        checkOutput(16);

        $display("[TB] abort with en during data bit 3");
        applyStimulus(8'h33, 2'b11, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        g = 0;
        fell = 0;
        while (!fell && g < 80) begin
            wait_neg();
            g++;
            if (tx === 1'b0) fell = 1;
        end
        check_eq("abort_start_fall", fell, 1'b1);
        repeat (7 + 64) wait_neg();
        check_eq("abort_bit3", tx, 1'b0);
        en = 1'b0;
        wait_neg();
        check_eq("abort_tx", tx, 1'b1);
        check_eq("abort_busy", tx_busy, 1'b0);
        check_eq("abort_ready_off", tx_ready, 1'b0);
        changes = 0;
        repeat (40) begin
            wait_neg();
            if (tx !== 1'b1 || tx_busy !== 1'b0) changes++;
        end
        en = 1'b1;
        repeat (40) begin
            wait_neg();
            if (tx !== 1'b1 || tx_busy !== 1'b0) changes++;
        end
        check_eq("abort_quiet", changes, 0);
        check_eq("abort_ready_back", tx_ready, 1'b1);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        g = 0;
        fell = 0;
        while (!fell && g < 80) begin
            wait_neg();
            g++;
            if (tx === 1'b0) fell = 1;
        end
        check_eq("rst_start_fall", fell, 1'b1);
        repeat (40) wait_neg();
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_tx", tx, 1'b1);
        check_eq("rst_async_busy", tx_busy, 1'b0);
        wait_neg();
        rst_n = 1'b1;
        wait_neg();
        applyStimulus(8'hC5, 2'b11, 1'b0, 1'b0, 1'b0, 1, 0, 0);
        checkOutput(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
